// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit single-cycle CPU.
// Fetch FSM states and next-PC control bundle.
package cpu_pkg;

  localparam int DATA_W = 16;
  localparam logic [15:0] RESET_PC = 16'h0000;
  localparam int INSTR_BYTES = 2;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    EXEC,
    HALTED
  } pc_state_t;

  typedef struct packed {
    logic halt;
    logic jump;
    logic branch;
  } pc_ctrl_t;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC selection: halt > jump > branch > sequential.
// Purely combinational; all arithmetic wraps modulo 2^DATA_W.
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic [DATA_W-1:0] pc,
  input  logic [DATA_W-1:0] branch_offset,
  input  logic [DATA_W-1:0] jump_addr,
  input  pc_ctrl_t          ctrl,
  output logic [DATA_W-1:0] next_pc,
  output logic [DATA_W-1:0] pc_plus2
);

  logic sel_halt;
  logic sel_jump;
  logic sel_br;
  logic sel_seq;

  logic [DATA_W-1:0] br_target;
  logic [DATA_W-1:0] jmp_target;

  assign pc_plus2   = pc + DATA_W'(INSTR_BYTES);
  assign br_target  = pc_plus2 + (branch_offset << 1);
  assign jmp_target = jump_addr & ~DATA_W'(1);

  // One-hot select so the decoder below is truly unique
  assign sel_halt = ctrl.halt;
  assign sel_jump = ctrl.jump & ~ctrl.halt;
  assign sel_br   = ctrl.branch & ~ctrl.jump & ~ctrl.halt;
  assign sel_seq  = ~ctrl.branch & ~ctrl.jump & ~ctrl.halt;

  always_comb begin
    next_pc = pc_plus2;
    unique case (1'b1)
      sel_halt: next_pc = pc;
      sel_jump: next_pc = jmp_target;
      sel_br:   next_pc = br_target;
      sel_seq:  next_pc = pc_plus2;
    endcase
  end

endmodule

// File: rtl/program_counter.sv
// PC register and req/ack fetch sequencer for the single-cycle CPU.
// Moore FSM: IDLE -> FETCH -> EXEC -> FETCH ... or HALTED.
module program_counter
  import cpu_pkg::*;
#(
  parameter int          DATA_W   = cpu_pkg::DATA_W,
  parameter logic [DATA_W-1:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Branch_out,
  input  logic [DATA_W-1:0] Branch_offset,
  input  logic              Jump,
  input  logic [DATA_W-1:0] Jump_addr,
  input  logic              Halt,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] Instr,
  output logic              instr_valid,
  output logic [DATA_W-1:0] PC,
  output logic [DATA_W-1:0] PC_plus2,
  output logic              halted
);

  pc_state_t state_q;
  pc_state_t state_d;

  logic [DATA_W-1:0] pc_q;
  logic [DATA_W-1:0] instr_q;
  logic [DATA_W-1:0] next_pc;
  logic              in_exec;
  logic              in_fetch;
  pc_ctrl_t          ctrl;

  assign in_exec  = (state_q == EXEC);
  assign in_fetch = (state_q == FETCH);

  // Controls only matter in EXEC; mask them elsewhere
  assign ctrl.halt   = Halt & in_exec;
  assign ctrl.jump   = Jump & in_exec;
  assign ctrl.branch = Branch_out & in_exec;

  pc_next_sel #(
    .DATA_W(DATA_W)
  ) u_next (
    .pc           (pc_q),
    .branch_offset(Branch_offset),
    .jump_addr    (Jump_addr),
    .ctrl         (ctrl),
    .next_pc      (next_pc),
    .pc_plus2     (PC_plus2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   state_d = FETCH;
      FETCH:  if (imem_ack) state_d = EXEC;
      EXEC:   state_d = Halt ? HALTED : FETCH;
      HALTED: state_d = HALTED;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= RESET_PC;
    end else if (in_exec) begin
      pc_q <= next_pc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
    end else if (in_fetch && imem_ack) begin
      instr_q <= imem_rdata;
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    unique case (state_q)
      IDLE:   ;
      FETCH:  imem_req = 1'b1;
      EXEC:   instr_valid = 1'b1;
      HALTED: halted = 1'b1;
    endcase
  end

  assign imem_addr = pc_q;
  assign PC        = pc_q;
  assign Instr     = instr_q;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: fetch timing, wait states,
// branch/jump/halt next-PC selection and asynchronous reset.
module tb_program_counter;

  logic        clk;
  logic        rst_n;
  logic        Branch_out;
  logic [15:0] Branch_offset;
  logic        Jump;
  logic [15:0] Jump_addr;
  logic        Halt;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] Instr;
  logic        instr_valid;
  logic [15:0] PC;
  logic [15:0] PC_plus2;
  logic        halted;

  int total;
  int bad;

  program_counter dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .Branch_out   (Branch_out),
    .Branch_offset(Branch_offset),
    .Jump         (Jump),
    .Jump_addr    (Jump_addr),
    .Halt         (Halt),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .Instr        (Instr),
    .instr_valid  (instr_valid),
    .PC           (PC),
    .PC_plus2     (PC_plus2),
    .halted       (halted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_ctrl();
    Branch_out    = 1'b0;
    Branch_offset = 16'h0000;
    Jump          = 1'b0;
    Jump_addr     = 16'h0000;
    Halt          = 1'b0;
  endtask

  // From FETCH: zero-wait ack, land in EXEC
  task automatic fetch(input logic [15:0] word);
    imem_ack   = 1'b1;
    imem_rdata = word;
    step();
    imem_ack   = 1'b0;
  endtask

  // From FETCH: fetch, then jump to tgt, land in FETCH at tgt
  task automatic go_to(input logic [15:0] tgt);
    fetch(16'h0000);
    Jump      = 1'b1;
    Jump_addr = tgt;
    step();
    clr_ctrl();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    imem_ack   = 1'b0;
    imem_rdata = 16'h0000;
    clr_ctrl();

    #12;
    chk("rst_pc", PC, 16'h0000);
    chk("rst_pc2", PC_plus2, 16'h0002);
    chk("rst_req", {15'd0, imem_req}, 16'd0);
    chk("rst_valid", {15'd0, instr_valid}, 16'd0);
    chk("rst_halted", {15'd0, halted}, 16'd0);
    chk("rst_instr", Instr, 16'h0000);

    // Release just after an edge: remainder is cycle 1
    @(posedge clk);
    #1 rst_n = 1'b1;
    chk("c1_req", {15'd0, imem_req}, 16'd0);
    step();
    chk("c2_req", {15'd0, imem_req}, 16'd1);
    chk("c2_addr", imem_addr, 16'h0000);

    fetch(16'h1234);
    chk("ex_instr", Instr, 16'h1234);
    chk("ex_valid", {15'd0, instr_valid}, 16'd1);
    chk("ex_req", {15'd0, imem_req}, 16'd0);
    imem_rdata = 16'h5555;
    step();
    chk("f2_valid", {15'd0, instr_valid}, 16'd0);
    chk("f2_req", {15'd0, imem_req}, 16'd1);
    chk("f2_addr", imem_addr, 16'h0002);
    chk("f2_pc2", PC_plus2, 16'h0004);

    // Wait states; controls in FETCH must be ignored
    Jump = 1'b1;
    Jump_addr = 16'h0F00;
    Halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("ws_req", {15'd0, imem_req}, 16'd1);
      chk("ws_addr", imem_addr, 16'h0002);
      chk("ws_valid", {15'd0, instr_valid}, 16'd0);
      chk("ws_halted", {15'd0, halted}, 16'd0);
    end
    clr_ctrl();
    fetch(16'hABCD);
    chk("ws_instr", Instr, 16'hABCD);
    chk("ws_valid1", {15'd0, instr_valid}, 16'd1);

    // Jump with odd address clears bit 0
    Jump = 1'b1;
    Jump_addr = 16'h0011;
    step();
    clr_ctrl();
    chk("jmp_odd", PC, 16'h0010);

    // Taken branch, offset -4 words
    fetch(16'h0000);
    Branch_out = 1'b1;
    Branch_offset = 16'hFFFC;
    step();
    clr_ctrl();
    chk("br_taken", PC, 16'h000A);

    // Not taken from 0x0010
    go_to(16'h0010);
    fetch(16'h0000);
    Branch_offset = 16'hFFFC;
    step();
    clr_ctrl();
    chk("br_not", PC, 16'h0012);

    // Jump beats branch
    fetch(16'h0000);
    Jump = 1'b1;
    Jump_addr = 16'h0101;
    Branch_out = 1'b1;
    Branch_offset = 16'h0007;
    step();
    clr_ctrl();
    chk("jmp_prio", PC, 16'h0100);

    // Sequential wrap
    go_to(16'hFFFE);
    chk("wrap_pc2", PC_plus2, 16'h0000);
    fetch(16'h0000);
    step();
    chk("wrap_pc", PC, 16'h0000);

    // Halt beats jump; then absorb stray acks
    go_to(16'h0040);
    fetch(16'h7777);
    Halt = 1'b1;
    Jump = 1'b1;
    Jump_addr = 16'h0200;
    step();
    clr_ctrl();
    chk("h_halted", {15'd0, halted}, 16'd1);
    chk("h_pc", PC, 16'h0040);
    chk("h_req", {15'd0, imem_req}, 16'd0);
    chk("h_valid", {15'd0, instr_valid}, 16'd0);
    imem_ack = 1'b1;
    imem_rdata = 16'hDEAD;
    Jump = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("h_stay", {15'd0, halted}, 16'd1);
      chk("h_noreq", {15'd0, imem_req}, 16'd0);
      chk("h_instr", Instr, 16'h7777);
      chk("h_pcst", PC, 16'h0040);
    end
    imem_ack = 1'b0;
    clr_ctrl();

    // Reset out of HALTED, restart
    rst_n = 1'b0;
    #1;
    chk("hr_halted", {15'd0, halted}, 16'd0);
    chk("hr_pc", PC, 16'h0000);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("hr_req", {15'd0, imem_req}, 16'd1);
    fetch(16'h2222);
    step();
    chk("hr_addr", imem_addr, 16'h0002);

    // Reset mid-FETCH with ack pending, no clock edge
    imem_ack = 1'b1;
    imem_rdata = 16'h9999;
    #2 rst_n = 1'b0;
    #1;
    chk("mf_req", {15'd0, imem_req}, 16'd0);
    chk("mf_pc", PC, 16'h0000);
    chk("mf_instr", Instr, 16'h0000);
    step();
    chk("mf_hold", {15'd0, imem_req}, 16'd0);
    imem_ack = 1'b0;
    #1 rst_n = 1'b1;
    chk("mf_c1", {15'd0, imem_req}, 16'd0);
    step();
    chk("mf_c2", {15'd0, imem_req}, 16'd1);
    chk("mf_addr", imem_addr, 16'h0000);

    // Reset mid-EXEC drops instr_valid, no PC update
    fetch(16'h3333);
    chk("me_valid", {15'd0, instr_valid}, 16'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("me_drop", {15'd0, instr_valid}, 16'd0);
    step();
    chk("me_pc", PC, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
